// File: rtl/dsp_skid_stage.sv
// ============================================================================
// Module      : dsp_skid_stage
// Description : Two-entry valid/ready skid buffer for DSP48A1 operand/result
//               paths; optional stall counter when DSP_SKID_STATS_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dsp_skid_stage #(
  parameter int WIDTH  = 18,
  parameter int BYPASS = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ce,
  input  logic             sclr,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data,
`ifdef DSP_SKID_STATS_EN
  output logic [15:0]      stall_cnt,
`endif
  output logic [1:0]       level
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  generate
    if (BYPASS != 0) begin : g_bypass
      // Control inputs have no meaning without storage.
      logic w_unused;
      assign w_unused  = &{1'b0, clk, rst, ce, sclr};
      assign s_ready   = m_ready;
      assign m_valid   = s_valid;
      assign m_data    = s_data;
      assign level     = 2'd0;
`ifdef DSP_SKID_STATS_EN
      assign stall_cnt = 16'd0;
`endif
    end else begin : g_skid
      state_t           r_state;
      state_t           w_state_nxt;
      logic [WIDTH-1:0] r_main;
      logic [WIDTH-1:0] r_skid;
      logic             w_in;
      logic             w_out;
      logic             w_main_from_s;
      logic             w_main_from_skid;
      logic             w_skid_load;

      // Handshakes decode registered state only, so no ready path runs through.
      assign s_ready = ce & (r_state != ST_TWO);
      assign m_valid = ce & (r_state != ST_EMPTY);
      assign m_data  = r_main;
      assign level   = r_state;
      assign w_in    = s_valid & s_ready;
      assign w_out   = m_valid & m_ready;

      always_comb begin
        w_state_nxt      = r_state;
        w_main_from_s    = 1'b0;
        w_main_from_skid = 1'b0;
        w_skid_load      = 1'b0;
        if (ce) begin
          if (sclr) begin
            w_state_nxt = ST_EMPTY;
          end else begin
            case (r_state)
              ST_EMPTY: begin
                if (w_in) begin
                  w_state_nxt   = ST_ONE;
                  w_main_from_s = 1'b1;
                end
              end
              ST_ONE: begin
                if (w_in && !w_out) begin
                  w_state_nxt = ST_TWO;
                  w_skid_load = 1'b1;
                end else if (!w_in && w_out) begin
                  w_state_nxt = ST_EMPTY;
                end else if (w_in && w_out) begin
                  w_main_from_s = 1'b1;
                end
              end
              ST_TWO: begin
                if (w_out) begin
                  w_state_nxt      = ST_ONE;
                  w_main_from_skid = 1'b1;
                end
              end
              default: w_state_nxt = ST_EMPTY;
            endcase
          end
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_state <= ST_EMPTY;
          r_main  <= '0;
          r_skid  <= '0;
        end else begin
          r_state <= w_state_nxt;
          if (w_main_from_s)
            r_main <= s_data;
          else if (w_main_from_skid)
            r_main <= r_skid;
          if (w_skid_load)
            r_skid <= s_data;
        end
      end

`ifdef DSP_SKID_STATS_EN
      logic [15:0] r_stall_cnt;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_stall_cnt <= 16'd0;
        end else if (ce) begin
          if (sclr)
            r_stall_cnt <= 16'd0;
          else if (m_valid && !m_ready && (r_stall_cnt != 16'hFFFF))
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
      end

      assign stall_cnt = r_stall_cnt;
`endif
    end
  endgenerate

endmodule

`default_nettype wire
